// File: rtl/meas_uart_sender_if.sv
// Measurement-to-UART bundle: CORDIC result in, serial line and status out.
interface meas_uart_sender_if;
  logic        end_cordic;
  logic [15:0] data_sqrt;
  logic [18:0] angle;
  logic [5:0]  addr;
  logic [1:0]  method_state;
  logic        uart_txd;
  logic        end_send_uart;
  logic        busy;

  modport master (
    output end_cordic, data_sqrt, angle, addr, method_state,
    input  uart_txd, end_send_uart, busy
  );

  modport slave (
    input  end_cordic, data_sqrt, angle, addr, method_state,
    output uart_txd, end_send_uart, busy
  );
endinterface

// File: rtl/meas_uart_sender.sv
// Frames one CORDIC measurement as 8N1 UART bytes behind a 0xA5 header.
// Define MEAS_UART_CHECKSUM_EN to append a mod-256 checksum byte.
module meas_uart_sender #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rstn,
  meas_uart_sender_if.slave bus
);

`ifdef MEAS_UART_CHECKSUM_EN
  localparam int NBYTES = 8;
`else
  localparam int NBYTES = 7;
`endif

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, NEXT, DONE
  } state_t;

  state_t      state, state_n;
  logic [11:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_n;
  logic [2:0]  byte_idx, byte_n;
  logic [1:0]  h_ms;
  logic [5:0]  h_addr;
  logic [15:0] h_mag;
  logic [18:0] h_ang;
  logic [7:0]  cur;
  logic        cap;
  logic        bit_end;
  logic        stop_end;
  logic        last_byte;
  logic        txd;

  assign cap = (state == IDLE) && bus.end_cordic
             && (bus.method_state != 2'b00);
  assign bit_end   = cnt == 12'(CLKS_PER_BIT - 1);
  assign stop_end  = cnt == 12'(CLKS_PER_BIT - 2);
  assign last_byte = byte_idx == 3'(NBYTES - 1);

`ifdef MEAS_UART_CHECKSUM_EN
  logic [7:0] csum;
  assign csum = 8'hA5 + {h_ms, h_addr}
              + h_mag[15:8] + h_mag[7:0]
              + {5'b0, h_ang[18:16]}
              + h_ang[15:8] + h_ang[7:0];
`endif

  always_comb begin
    cur = 8'hA5;
    case (byte_idx)
      3'd0: cur = 8'hA5;
      3'd1: cur = {h_ms, h_addr};
      3'd2: cur = h_mag[15:8];
      3'd3: cur = h_mag[7:0];
      3'd4: cur = {5'b0, h_ang[18:16]};
      3'd5: cur = h_ang[15:8];
      3'd6: cur = h_ang[7:0];
`ifdef MEAS_UART_CHECKSUM_EN
      3'd7: cur = csum;
`endif
      default: cur = 8'hA5;
    endcase
  end

  // STOP runs one cycle short; NEXT supplies the last stop-bit cycle
  always_comb begin
    state_n = state;
    cnt_n   = '0;
    bit_n   = bit_idx;
    byte_n  = byte_idx;
    unique case (state)
      IDLE: begin
        bit_n  = '0;
        byte_n = '0;
        if (cap) state_n = START;
      end
      START: begin
        if (bit_end) state_n = DATA;
        else cnt_n = cnt + 12'd1;
      end
      DATA: begin
        if (bit_end) begin
          bit_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end else begin
          cnt_n = cnt + 12'd1;
        end
      end
      STOP: begin
        if (stop_end) state_n = NEXT;
        else cnt_n = cnt + 12'd1;
      end
      NEXT: begin
        byte_n  = byte_idx + 3'd1;
        state_n = last_byte ? DONE : START;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      h_ms     <= '0;
      h_addr   <= '0;
      h_mag    <= '0;
      h_ang    <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_n;
      byte_idx <= byte_n;
      if (cap) begin
        h_ms   <= bus.method_state;
        h_addr <= bus.addr;
        h_mag  <= bus.data_sqrt;
        h_ang  <= bus.angle;
      end
    end
  end

  always_comb begin
    txd = 1'b1;
    if (state == START) txd = 1'b0;
    if (state == DATA)  txd = cur[bit_idx];
  end

  assign bus.uart_txd      = txd;
  assign bus.end_send_uart = state == DONE;
  assign bus.busy          = state != IDLE;

endmodule
